// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: latches one request, waits a fixed
// settle time, captures the result and holds it until the consumer takes it.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [2:0]  req_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_opcode,
   input  logic [63:0] alu_res,
   input  logic        alu_ov,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_res,
   output logic        rsp_ov,
   output logic        rsp_dz,
   output logic [2:0]  rsp_op,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       capture;
   logic       handshake;

   // Overflow/carry is only meaningful for add and subtract.
   function automatic logic ov_for_op(input logic [2:0] op, input logic ov);
      return ((op == 3'b000) || (op == 3'b001)) ? ov : 1'b0;
   endfunction

   function automatic logic is_div_zero(input logic [2:0] op, input logic [31:0] b);
      return (op == 3'b011) && (b == 32'd0);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and handshake strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            if (req_valid && !rst) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            // <= guards against a stuck counter if it were ever found at zero
            if (settle_cnt <= 4'd1) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = RESP;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand latch, settle counter, response capture and completion count
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a      <= 32'd0;
         alu_b      <= 32'd0;
         alu_opcode <= 3'd0;
         settle_cnt <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_res    <= 64'd0;
         rsp_ov     <= 1'b0;
         rsp_dz     <= 1'b0;
         rsp_op     <= 3'd0;
         busy       <= 1'b0;
         op_count   <= 16'd0;
      end else begin
         if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= req_op;
            settle_cnt <= SETTLE_INIT;
         end else if (state == WAIT) begin
            settle_cnt <= settle_cnt - 4'd1;
         end else begin
            settle_cnt <= settle_cnt;
         end
         if (capture) begin
            rsp_res <= alu_res;
            rsp_ov  <= ov_for_op(alu_opcode, alu_ov);
            rsp_dz  <= is_div_zero(alu_opcode, alu_b);
            rsp_op  <= alu_opcode;
         end else begin
            rsp_res <= rsp_res;
         end
         if (handshake) begin
            op_count <= op_count + 16'd1;
         end else begin
            op_count <= op_count;
         end
         rsp_valid <= (state_nxt == RESP);
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule
